// File: rtl/jt900h_useq_pkg.sv
// Shared 900h parameter package: sequencer command encodings and flag bit indices.
package jt900h_useq_pkg;

  localparam int unsigned CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_NEXT = 3'd0,
    CMD_JSR  = 3'd1,
    CMD_RET  = 3'd2,
    CMD_NI   = 3'd3,
    CMD_JMP  = 3'd4,
    CMD_LSET = 3'd5,
    CMD_LOOP = 3'd6,
    CMD_RSV  = 3'd7   // reserved, behaves as NEXT
  } cmd_e;

  // Flag register bit positions
  localparam int unsigned FLAG_S = 7;
  localparam int unsigned FLAG_Z = 6;
  localparam int unsigned FLAG_H = 4;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/jt900h_ustack.sv
// Microcode return stack.
//   clk/rst : clock, synchronous active-high reset (clears occupancy only)
//   push/pop: single-cycle requests (never together); clr empties the stack
//   din     : value pushed;  top: most recent entry (valid only when !empty)
//   full/empty/sp : occupancy status
module jt900h_ustack #(
  parameter int unsigned DW    = 14,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           clr,
  input  logic [DW-1:0]                  din,
  output logic                           full,
  output logic                           empty,
  output logic [DW-1:0]                  top,
  output logic [$clog2(DEPTH+1)-1:0]     sp
);

  localparam int unsigned SPW   = $clog2(DEPTH + 1);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NSLOT = 1 << AW;

  logic [DW-1:0]  mem_q [NSLOT];
  logic [DW-1:0]  mem_d [NSLOT];
  logic [SPW-1:0] sp_q, sp_d;
  logic [AW-1:0]  wr_idx, top_idx;

  assign full    = (sp_q == SPW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign sp      = sp_q;
  assign wr_idx  = AW'(sp_q);
  assign top_idx = AW'(sp_q - SPW'(1));
  assign top     = mem_q[top_idx];

  // Next occupancy and entry contents
  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (clr) begin
      sp_d = '0;
    end else if (push && !full) begin
      mem_d[wr_idx] = din;
      sp_d          = sp_q + SPW'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  // Entries carry no reset; only occupancy is cleared
  always_ff @(posedge clk) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
    mem_q <= mem_d;
  end

endmodule

// File: rtl/jt900h_useq.sv
// 900H microcode sequencer: next-address selection, condition decode,
// return stack and a single hardware loop counter.
//   cen/stall : a cycle advances only when cen=1 and stall=0
//   cmd/cond/tgt/grp/md/flags/lcnt : microword command and operands
//   uaddr : registered microcode address;  cc : condition result (combinational)
//   sp    : return-stack occupancy;        err : sticky stack over/underflow
module jt900h_useq
  import jt900h_useq_pkg::*;
#(
  parameter int unsigned     UAW    = 14,
  parameter int unsigned     DEPTH  = 4,
  parameter int unsigned     LCW    = 8,
  parameter logic [UAW-1:0]  RST_UA = {UAW{1'b1}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cen,
  input  logic                         stall,
  input  logic [2:0]                   cmd,
  input  logic                         cond,
  input  logic [UAW-1:0]               tgt,
  input  logic [1:0]                   grp,
  input  logic [7:0]                   md,
  input  logic [7:0]                   flags,
  input  logic [LCW-1:0]               lcnt,
  output logic [UAW-1:0]               uaddr,
  output logic                         cc,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         err
);

  logic [UAW-1:0] uaddr_q, uaddr_d;
  logic [UAW-1:0] lstart_q, lstart_d;
  logic [LCW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;

  logic           push, pop, clr, full, empty;
  logic [UAW-1:0] top, inc;
  logic [13:0]    ni_ua;
  logic           adv, take, base;
  logic           fs, fz, fv, fc;
  logic           unused_flags;

  assign fs = flags[FLAG_S];
  assign fz = flags[FLAG_Z];
  assign fv = flags[FLAG_V];
  assign fc = flags[FLAG_C];
  assign unused_flags = ^{flags[FLAG_H], flags[FLAG_N], flags[5], flags[3]};

  // Codes 8..15 are the complements of 0..7 (8 = ~F = T)
  always_comb begin
    base = 1'b0;
    case (md[2:0])
      3'd0: base = 1'b0;
      3'd1: base = fs ^ fv;
      3'd2: base = fz | (fs ^ fv);
      3'd3: base = fz | fc;
      3'd4: base = fv;
      3'd5: base = fs;
      3'd6: base = fz;
      3'd7: base = fc;
      default: base = 1'b0;
    endcase
    cc = base ^ md[3];
  end

  assign adv   = cen & ~stall;
  assign take  = ~cond | cc;
  assign inc   = uaddr_q + UAW'(1);
  assign ni_ua = {grp, md, 4'd0};

  // Next-address and loop/stack control
  always_comb begin
    uaddr_d  = uaddr_q;
    lstart_d = lstart_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    push     = 1'b0;
    pop      = 1'b0;
    clr      = 1'b0;
    if (adv) begin
      case (cmd_e'(cmd))
        CMD_JSR: begin
          if (!take) begin
            uaddr_d = inc;
          end else if (full) begin
            uaddr_d = inc;
            err_d   = 1'b1;
          end else begin
            push    = 1'b1;
            uaddr_d = tgt;
          end
        end
        CMD_RET: begin
          if (empty) begin
            uaddr_d = inc;
            err_d   = 1'b1;
          end else begin
            pop     = 1'b1;
            uaddr_d = top;
          end
        end
        CMD_NI: begin
          uaddr_d = UAW'(ni_ua);
          clr     = 1'b1;
          cnt_d   = '0;
        end
        CMD_JMP:  uaddr_d = take ? tgt : inc;
        CMD_LSET: begin
          cnt_d    = lcnt;
          lstart_d = inc;
          uaddr_d  = inc;
        end
        CMD_LOOP: begin
          if (cnt_q > LCW'(1)) begin
            cnt_d   = cnt_q - LCW'(1);
            uaddr_d = lstart_q;
          end else begin
            cnt_d   = '0;
            uaddr_d = inc;
          end
        end
        default: uaddr_d = inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uaddr_q  <= RST_UA;
      lstart_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      uaddr_q  <= uaddr_d;
      lstart_q <= lstart_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  jt900h_ustack #(
    .DW    (UAW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clr   (clr),
    .din   (inc),
    .full  (full),
    .empty (empty),
    .top   (top),
    .sp    (sp)
  );

  assign uaddr = uaddr_q;
  assign err   = err_q;

endmodule

// File: tb/tb_jt900h_useq.sv
// Randomised scoreboard bench for jt900h_useq against a queue-based reference model.
module tb_jt900h_useq;

  localparam int unsigned UAW   = 14;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LCW   = 8;
  localparam int unsigned MASK  = (1 << UAW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0, cen = 1'b0, stall = 1'b0, cond = 1'b0;
  logic [2:0]     cmd = '0;
  logic [UAW-1:0] tgt = '0;
  logic [1:0]     grp = '0;
  logic [7:0]     md = '0, flags = '0;
  logic [LCW-1:0] lcnt = '0;
  logic [UAW-1:0] uaddr;
  logic           cc, err;
  logic [2:0]     sp;

  jt900h_useq #(.UAW(UAW), .DEPTH(DEPTH), .LCW(LCW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .stall(stall), .cmd(cmd), .cond(cond),
    .tgt(tgt), .grp(grp), .md(md), .flags(flags), .lcnt(lcnt),
    .uaddr(uaddr), .cc(cc), .sp(sp), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [UAW-1:0] ua;
    logic [2:0]     sp;
    logic           err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int unsigned m_ua = 0, m_cnt = 0, m_ls = 0;
  int unsigned m_stk[$];
  bit          m_err = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_cc(input logic [7:0] m, input logic [7:0] f);
    bit s, z, v, c;
    s = f[7]; z = f[6]; v = f[2]; c = f[0];
    case (m[3:0])
      4'd0:  return 1'b0;
      4'd1:  return s ^ v;
      4'd2:  return z | (s ^ v);
      4'd3:  return z | c;
      4'd4:  return v;
      4'd5:  return s;
      4'd6:  return z;
      4'd7:  return c;
      4'd8:  return 1'b1;
      4'd9:  return !(s ^ v);
      4'd10: return !(z | (s ^ v));
      4'd11: return !(z | c);
      4'd12: return !v;
      4'd13: return !s;
      4'd14: return !z;
      default: return !c;
    endcase
  endfunction

  task automatic model_step();
    int unsigned nxt;
    bit taken;
    nxt   = (m_ua + 1) & MASK;
    taken = !cond || model_cc(md, flags);
    if (rst) begin
      m_ua = MASK; m_stk.delete(); m_err = 0; m_cnt = 0; m_ls = 0;
    end else if (cen && !stall) begin
      case (cmd)
        3'd1: begin
          if (!taken) m_ua = nxt;
          else if (m_stk.size() == DEPTH) begin m_ua = nxt; m_err = 1; end
          else begin m_stk.push_back(nxt); m_ua = tgt; end
        end
        3'd2: begin
          if (m_stk.size() == 0) begin m_ua = nxt; m_err = 1; end
          else m_ua = m_stk.pop_back();
        end
        3'd3: begin
          m_ua = ((int'(grp) << 12) | (int'(md) << 4)) & MASK;
          m_stk.delete(); m_cnt = 0;
        end
        3'd4: m_ua = taken ? int'(tgt) : nxt;
        3'd5: begin m_cnt = lcnt; m_ls = nxt; m_ua = nxt; end
        3'd6: begin
          if (m_cnt > 1) begin m_cnt--; m_ua = m_ls; end
          else begin m_cnt = 0; m_ua = nxt; end
        end
        default: m_ua = nxt;
      endcase
    end
  endtask

  // Drive one cycle on the falling edge, check cc, queue the post-edge expectation
  task automatic issue(input logic r, input logic c, input logic s, input logic [2:0] cm,
                       input logic cd, input logic [UAW-1:0] t, input logic [1:0] g,
                       input logic [7:0] m, input logic [7:0] f, input logic [LCW-1:0] l);
    exp_t e;
    @(negedge clk);
    rst = r; cen = c; stall = s; cmd = cm; cond = cd; tgt = t;
    grp = g; md = m; flags = f; lcnt = l;
    #1;
    chk("cc", cc, model_cc(m, f));
    model_step();
    e.ua = m_ua[UAW-1:0]; e.sp = 3'(m_stk.size()); e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic op(input logic [2:0] cm, input logic [UAW-1:0] t);
    issue(1'b0, 1'b1, 1'b0, cm, 1'b0, t, 2'd0, 8'h00, 8'h00, '0);
  endtask

  task automatic lset(input logic [LCW-1:0] l);
    issue(1'b0, 1'b1, 1'b0, 3'd5, 1'b0, '0, 2'd0, 8'h00, 8'h00, l);
  endtask

  task automatic do_rst();
    issue(1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 14'h0abc, 2'd0, 8'h00, 8'h00, '0);
  endtask

  // Spec-derived spot checks of the post-edge state
  task automatic expect_st(input string nm, input int unsigned ua, input int unsigned s,
                           input int unsigned e);
    @(posedge clk); #2;
    chk({nm, ".uaddr"}, uaddr, ua);
    chk({nm, ".sp"}, sp, s);
    chk({nm, ".err"}, err, e);
  endtask

  // Monitor: compare every presented state against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb.uaddr", uaddr, e.ua);
        chk("sb.sp", sp, e.sp);
        chk("sb.err", err, e.err);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    do_rst();                       expect_st("reset", 14'h3fff, 0, 0);
    op(3'd0, '0);                   expect_st("wrap", 14'h0000, 0, 0);
    op(3'd4, 14'h0010);             expect_st("jmp10", 14'h0010, 0, 0);
    op(3'd1, 14'h0100);             expect_st("jsr1", 14'h0100, 1, 0);
    op(3'd1, 14'h0200);             expect_st("jsr2", 14'h0200, 2, 0);
    op(3'd2, '0);                   expect_st("ret1", 14'h0101, 1, 0);
    op(3'd2, '0);                   expect_st("ret2", 14'h0011, 0, 0);

    // Overflow on the fifth nested call
    op(3'd1, 14'h0300); op(3'd1, 14'h0301); op(3'd1, 14'h0302); op(3'd1, 14'h0303);
    op(3'd1, 14'h0400);             expect_st("ovf", 14'h0304, 4, 1);

    // Underflow after a fresh reset
    do_rst();
    op(3'd2, '0);                   expect_st("unf", 14'h0000, 0, 1);

    // Hardware loop: body 0021-0022 three times, then fall through
    op(3'd4, 14'h0020);
    lset(8'd3);                     expect_st("lset", 14'h0021, 0, 1);
    for (int i = 0; i < 2; i++) begin op(3'd0, '0); op(3'd6, '0); end
    op(3'd0, '0);
    op(3'd6, '0);                   expect_st("loopend", 14'h0023, 0, 1);
    lset(8'd0); op(3'd6, '0);       expect_st("lcnt0", 14'h0025, 0, 1);
    lset(8'd1); op(3'd6, '0);       expect_st("lcnt1", 14'h0027, 0, 1);

    // Conditional jump on Z, then stall and cen holds
    issue(1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 14'h0100, 2'd0, 8'h06, 8'h00, '0);
    expect_st("jmpz0", 14'h0028, 0, 1);
    issue(1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 14'h0100, 2'd0, 8'h06, 8'h40, '0);
    expect_st("jmpz1", 14'h0100, 0, 1);
    for (int i = 0; i < 3; i++)
      issue(1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 14'h0200, 2'd0, 8'h00, 8'h00, '0);
    expect_st("stall", 14'h0100, 0, 1);
    issue(1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 14'h0200, 2'd0, 8'h00, 8'h00, '0);
    expect_st("cen0", 14'h0100, 0, 1);

    // NI flushes the stack
    op(3'd1, 14'h0010); op(3'd1, 14'h0020);
    issue(1'b0, 1'b1, 1'b0, 3'd3, 1'b0, '0, 2'd1, 8'ha5, 8'h00, '0);
    expect_st("ni", 14'h1a50, 0, 1);

    // Randomised phase
    for (int n = 0; n < 3000; n++) begin
      issue($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 14'($urandom),
            2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 4)));
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
